// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Core data-port bundle between the core (master) and the
//               data-memory controller (slave).
// Revision    : 1.0
// ============================================================================
interface dmem_ctrl_if;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic        err;

    modport master (
        output data_addr, data_in, mem_read, mem_write,
        input  data_out, rd_valid, stall, err
    );

    modport slave (
        input  data_addr, data_in, mem_read, mem_write,
        output data_out, rd_valid, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Word-addressed data RAM with configurable access latency.
//               It stalls the core until each load or store completes.
//               Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned
//               requests into a one-cycle err pulse.
// Revision    : 1.0
// ============================================================================
module dmem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    dmem_ctrl_if.slave  bus
);
    localparam int c_addrW = $clog2(DEPTH);

    localparam logic [1:0] c_stIdle = 2'd0;
    localparam logic [1:0] c_stWait = 2'd1;
    localparam logic [1:0] c_stResp = 2'd2;

    localparam logic [CNT_W-1:0] c_cntInit =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    logic [31:0]        r_mem [DEPTH];
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_addrW-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic               r_isWrite;
    logic [31:0]        r_dataOut;

    logic [c_addrW-1:0] w_idx;
    logic               w_req;
    logic               w_misalign;
    logic               w_accept;
    logic               w_wrEn;
    logic [c_addrW-1:0] w_wrIdx;
    logic [31:0]        w_wrData;
    logic               w_unusedAddr;

    assign w_idx        = bus.data_addr[c_addrW+1:2];
    assign w_req        = bus.mem_read | bus.mem_write;
    assign w_unusedAddr = ^{bus.data_addr[31:c_addrW+2], bus.data_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (r_state == c_stIdle) && w_req && (bus.data_addr[1:0] != 2'b00);
    assign bus.err    = w_misalign && !reset;
`else
    assign w_misalign = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign w_accept = (r_state == c_stIdle) && w_req && !w_misalign;

    // Gating with reset lets stall drop the instant reset rises, even mid-access.
    assign bus.stall    = !reset && (w_accept || (r_state == c_stWait));
    assign bus.rd_valid = (r_state == c_stResp) && !r_isWrite;
    assign bus.data_out = r_dataOut;

    // With zero wait states the access happens straight from IDLE on live inputs.
    assign w_wrEn   = (w_accept && bus.mem_write && (WAIT_STATES == 0)) ||
                      ((r_state == c_stWait) && (r_cnt == '0) && r_isWrite);
    assign w_wrIdx  = (r_state == c_stIdle) ? w_idx : r_idx;
    assign w_wrData = (r_state == c_stIdle) ? bus.data_in : r_wdata;

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[w_wrIdx] <= w_wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_stIdle;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_isWrite <= 1'b0;
            r_dataOut <= '0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (w_accept) begin
                        r_idx     <= w_idx;
                        r_wdata   <= bus.data_in;
                        r_isWrite <= bus.mem_write;
                        if (WAIT_STATES == 0) begin
                            r_state <= c_stResp;
                            if (!bus.mem_write) begin
                                r_dataOut <= r_mem[w_idx];
                            end
                        end else begin
                            r_state <= c_stWait;
                            r_cnt   <= c_cntInit;
                        end
                    end
                end
                c_stWait: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= c_stResp;
                        if (!r_isWrite) begin
                            r_dataOut <= r_mem[r_idx];
                        end
                    end
                end
                // The core advances on this edge; a still-held request is not re-issued.
                c_stResp: r_state <= c_stIdle;
                default:  r_state <= c_stIdle;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Randomized self-checking bench for dmem_ctrl against an
//               array-based memory model with fixed-latency expectations.
// Revision    : 1.0
// ============================================================================
module tb_dmem_ctrl;
    localparam int DEPTH       = 256;
    localparam int WAIT_STATES = 2;
    localparam int CNT_W       = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] mdlMem [DEPTH];
    bit          mdlVld [DEPTH];
    logic [31:0] mdlOut = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Tasks start just after a rising edge; outputs are sampled on the falling edge.
    task automatic idleCycle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_rdv", 32'(bus.rd_valid), 32'd0);
        chk("idle_err", 32'(bus.err), 32'd0);
        chk("idle_dout", bus.data_out, mdlOut);
        @(posedge clk); #1;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble);
        int idx;
        idx = idxOf(addr);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.data_addr = addr;
        bus.data_in   = data;
        for (int c = 0; c <= WAIT_STATES; c++) begin
            @(negedge clk);
            chk("acc_stall", 32'(bus.stall), 32'd1);
            chk("acc_rdv", 32'(bus.rd_valid), 32'd0);
            chk("acc_dout_hold", bus.data_out, mdlOut);
            @(posedge clk); #1;
            if (scramble) begin
                bus.data_addr = $urandom;
                bus.data_in   = $urandom;
            end
        end
        if (wr) begin
            mdlMem[idx] = data;
            mdlVld[idx] = 1'b1;
        end else begin
            mdlOut = mdlMem[idx];
        end
        @(negedge clk);
        chk("resp_stall", 32'(bus.stall), 32'd0);
        chk("resp_rdv", 32'(bus.rd_valid), 32'(!wr));
        chk("resp_dout", bus.data_out, mdlOut);
        chk("resp_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.data_addr = '0;
        bus.data_in   = '0;
        for (int i = 0; i < DEPTH; i++) mdlVld[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", bus.data_out, 32'h0);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        idleCycle();

        // Store then load, followed by an idle cycle where data_out must hold.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idleCycle();

        // Address aliasing modulo DEPTH*4.
        access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Read and write both high behaves as a write.
        access(1'b1, 1'b1, 32'h20, 32'h55, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Reset during WAIT of a store drops the write.
        bus.mem_write = 1'b1;
        bus.data_addr = 32'h20;
        bus.data_in   = 32'h77;
        @(negedge clk);
        chk("rstw_stall_idle", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_stall", 32'(bus.stall), 32'd0);
        chk("rstw_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rstw_dout", bus.data_out, 32'h0);
        mdlOut = 32'h0;
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idleCycle();
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Misaligned load of 0x13.
`ifdef DMEM_MISALIGN_TRAP_EN
        bus.mem_read  = 1'b1;
        bus.data_addr = 32'h13;
        @(negedge clk);
        chk("mis_err", 32'(bus.err), 32'd1);
        chk("mis_stall", 32'(bus.stall), 32'd0);
        chk("mis_rdv", 32'(bus.rd_valid), 32'd0);
        chk("mis_dout", bus.data_out, mdlOut);
        @(posedge clk); #1;
        idleCycle();
`else
        access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        chk("trunc_dout", bus.data_out, 32'hDEADBEEF);
`endif

        // Randomized accesses; reads only target words the model has written.
        for (int n = 0; n < 150; n++) begin
            int          idx;
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            logic [31:0] upper;
            idx = int'($urandom_range(0, 31));
            rd  = ($urandom_range(0, 1) == 1) && mdlVld[idx];
            wr  = !rd;
            if (wr && ($urandom_range(0, 3) == 0)) rd = 1'b1;
            upper = $urandom;
            addr  = (upper & ~32'(DEPTH * 4 - 1)) | 32'(idx * 4);
`ifndef DMEM_MISALIGN_TRAP_EN
            addr = addr | 32'($urandom_range(0, 3));
`endif
            access(rd, wr, addr, $urandom, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) idleCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
